// File: rtl/traffic_light_monitor.sv
// Traffic light lamp monitor: follows the green/yellow/red sequence and flags
// lamp-encoding, sequence and phase-duration errors; counts completed light cycles.
module traffic_light_monitor #(
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 5,
    parameter int RED_CYC    = 15,
    parameter int TOL        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       err_clr,
    output logic       locked,
    output logic [1:0] phase,
    output logic       err_onehot,
    output logic       err_seq,
    output logic       err_timing,
    output logic [7:0] cycle_cnt
);

    typedef enum logic [1:0] {
        SYNC   = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10,
        RED    = 2'b11
    } state_t;

    // Lower bounds clamp at zero so NOM-TOL can never wrap.
    localparam logic [15:0] G_LO = (GREEN_CYC  > TOL) ? 16'(GREEN_CYC  - TOL) : 16'd0;
    localparam logic [15:0] Y_LO = (YELLOW_CYC > TOL) ? 16'(YELLOW_CYC - TOL) : 16'd0;
    localparam logic [15:0] R_LO = (RED_CYC    > TOL) ? 16'(RED_CYC    - TOL) : 16'd0;
    localparam logic [15:0] G_HI = 16'(GREEN_CYC  + TOL);
    localparam logic [15:0] Y_HI = 16'(YELLOW_CYC + TOL);
    localparam logic [15:0] R_HI = 16'(RED_CYC    + TOL);

    state_t      state, state_nxt, lamp_phase, legal_nxt;
    logic [15:0] dur, dur_nxt;
    logic        partial, partial_nxt;
    logic        onehot, ev_onehot, ev_seq, ev_timing, cnt_inc;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] lo_of(input state_t s);
        case (s)
            GREEN:   return G_LO;
            YELLOW:  return Y_LO;
            RED:     return R_LO;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [15:0] hi_of(input state_t s);
        case (s)
            GREEN:   return G_HI;
            YELLOW:  return Y_HI;
            RED:     return R_HI;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic state_t next_of(input state_t s);
        case (s)
            GREEN:   return YELLOW;
            YELLOW:  return RED;
            RED:     return GREEN;
            default: return SYNC;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) state <= SYNC;
        else      state <= state_nxt;
    end

    always_comb begin
        onehot     = 1'b1;
        lamp_phase = SYNC;
        case ({red, yellow, green})
            3'b001:  lamp_phase = GREEN;
            3'b010:  lamp_phase = YELLOW;
            3'b100:  lamp_phase = RED;
            default: onehot = 1'b0;
        endcase

        legal_nxt   = next_of(state);
        state_nxt   = state;
        dur_nxt     = dur;
        partial_nxt = partial;
        ev_onehot   = 1'b0;
        ev_seq      = 1'b0;
        ev_timing   = 1'b0;
        cnt_inc     = 1'b0;

        if (state == SYNC) begin
            dur_nxt = 16'd0;
            if (onehot) begin
                state_nxt   = lamp_phase;
                dur_nxt     = 16'd1;
                partial_nxt = 1'b1;
            end
        end else if (!onehot) begin
            ev_onehot = 1'b1;
            state_nxt = SYNC;
            dur_nxt   = 16'd0;
        end else if (lamp_phase == state) begin
            // Overlong phase is reported as soon as it passes the upper bound.
            dur_nxt = sat_inc16(dur);
            if (!partial && dur_nxt == hi_of(state) + 16'd1) ev_timing = 1'b1;
        end else if (lamp_phase == legal_nxt) begin
            if (!partial && (dur < lo_of(state) || dur > hi_of(state))) ev_timing = 1'b1;
            state_nxt   = lamp_phase;
            dur_nxt     = 16'd1;
            partial_nxt = 1'b0;
            cnt_inc     = (state == RED);
        end else begin
            ev_seq    = 1'b1;
            state_nxt = SYNC;
            dur_nxt   = 16'd0;
        end
    end

    always_comb begin
        phase  = state;
        locked = (state != SYNC);
    end

    // A new error on the same edge as err_clr wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dur        <= 16'd0;
            partial    <= 1'b0;
            err_onehot <= 1'b0;
            err_seq    <= 1'b0;
            err_timing <= 1'b0;
            cycle_cnt  <= 8'd0;
        end else begin
            dur        <= dur_nxt;
            partial    <= partial_nxt;
            err_onehot <= (err_onehot & ~err_clr) | ev_onehot;
            err_seq    <= (err_seq    & ~err_clr) | ev_seq;
            err_timing <= (err_timing & ~err_clr) | ev_timing;
            if (cnt_inc) cycle_cnt <= sat_inc8(cycle_cnt);
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with G=8, Y=3, R=6, TOL=1.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       red = 1'b0, yellow = 1'b0, green = 1'b0;
    logic       err_clr = 1'b0;
    logic       locked;
    logic [1:0] phase;
    logic       err_onehot, err_seq, err_timing;
    logic [7:0] cycle_cnt;
    logic [13:0] st;

    int nvec = 0;
    int nerr = 0;

    localparam logic [2:0] L_R  = 3'b100;
    localparam logic [2:0] L_Y  = 3'b010;
    localparam logic [2:0] L_G  = 3'b001;
    localparam logic [2:0] L_0  = 3'b000;

    traffic_light_monitor #(
        .GREEN_CYC(8), .YELLOW_CYC(3), .RED_CYC(6), .TOL(1)
    ) dut (
        .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
        .err_clr(err_clr), .locked(locked), .phase(phase),
        .err_onehot(err_onehot), .err_seq(err_seq), .err_timing(err_timing),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Status word: {locked, phase, err_onehot, err_seq, err_timing, cycle_cnt}
    assign st = {locked, phase, err_onehot, err_seq, err_timing, cycle_cnt};

    task automatic drive(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) begin
            {red, yellow, green} = l;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        err_clr = 1'b0;
        drive(L_0, 2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(L_G, 2);
        nvec++;
        if (st !== {1'b0, 2'b00, 3'b000, 8'd0}) begin
            nerr++; $display("FAIL reset: status=%h want=%h", st, {1'b0, 2'b00, 3'b000, 8'd0});
        end
        rst = 1'b1;
    endtask

    task automatic test_nominal();
        do_reset();
        drive(L_0, 2);
        nvec++;
        if (st !== {1'b0, 2'b00, 3'b000, 8'd0}) begin
            nerr++; $display("FAIL sync_idle: status=%h want=%h", st, {1'b0, 2'b00, 3'b000, 8'd0});
        end
        drive(L_R, 1);
        nvec++;
        if (st !== {1'b1, 2'b11, 3'b000, 8'd0}) begin
            nerr++; $display("FAIL first_lock: status=%h want=%h", st, {1'b1, 2'b11, 3'b000, 8'd0});
        end
        drive(L_R, 3);
        for (int k = 0; k < 3; k++) begin
            drive(L_G, 8); drive(L_Y, 3); drive(L_R, 6);
        end
        nvec++;
        if (st !== {1'b1, 2'b11, 3'b000, 8'd3}) begin
            nerr++; $display("FAIL nominal_run: status=%h want=%h", st, {1'b1, 2'b11, 3'b000, 8'd3});
        end
    endtask

    task automatic test_timing_long();
        do_reset();
        drive(L_R, 2); drive(L_G, 8); drive(L_Y, 4);
        nvec++;
        if (st !== {1'b1, 2'b10, 3'b000, 8'd1}) begin
            nerr++; $display("FAIL yellow_4: status=%h want=%h", st, {1'b1, 2'b10, 3'b000, 8'd1});
        end
        drive(L_Y, 1);
        nvec++;
        if (st !== {1'b1, 2'b10, 3'b001, 8'd1}) begin
            nerr++; $display("FAIL yellow_timeout: status=%h want=%h", st, {1'b1, 2'b10, 3'b001, 8'd1});
        end
        drive(L_R, 6);
        nvec++;
        if (st !== {1'b1, 2'b11, 3'b001, 8'd1}) begin
            nerr++; $display("FAIL track_after_timeout: status=%h want=%h", st, {1'b1, 2'b11, 3'b001, 8'd1});
        end
    endtask

    task automatic test_timing_short();
        do_reset();
        drive(L_R, 2); drive(L_G, 8); drive(L_Y, 1);
        nvec++;
        if (st !== {1'b1, 2'b10, 3'b000, 8'd1}) begin
            nerr++; $display("FAIL short_before_exit: status=%h want=%h", st, {1'b1, 2'b10, 3'b000, 8'd1});
        end
        drive(L_R, 1);
        nvec++;
        if (st !== {1'b1, 2'b11, 3'b001, 8'd1}) begin
            nerr++; $display("FAIL short_yellow: status=%h want=%h", st, {1'b1, 2'b11, 3'b001, 8'd1});
        end
        do_reset();
        drive(L_R, 2); drive(L_G, 7); drive(L_Y, 3); drive(L_R, 6);
        drive(L_G, 9); drive(L_Y, 3); drive(L_R, 6);
        nvec++;
        if (st !== {1'b1, 2'b11, 3'b000, 8'd2}) begin
            nerr++; $display("FAIL green_7_9_in_tol: status=%h want=%h", st, {1'b1, 2'b11, 3'b000, 8'd2});
        end
    endtask

    task automatic test_seq_onehot();
        do_reset();
        drive(L_R, 2); drive(L_G, 3); drive(L_R, 1);
        nvec++;
        if (st !== {1'b0, 2'b00, 3'b010, 8'd1}) begin
            nerr++; $display("FAIL green_to_red: status=%h want=%h", st, {1'b0, 2'b00, 3'b010, 8'd1});
        end
        err_clr = 1'b1; drive(L_R, 1); err_clr = 1'b0;
        nvec++;
        if (st !== {1'b1, 2'b11, 3'b000, 8'd1}) begin
            nerr++; $display("FAIL seq_clear_relock: status=%h want=%h", st, {1'b1, 2'b11, 3'b000, 8'd1});
        end
        drive(L_R | L_Y, 1);
        nvec++;
        if (st !== {1'b0, 2'b00, 3'b100, 8'd1}) begin
            nerr++; $display("FAIL multi_hot: status=%h want=%h", st, {1'b0, 2'b00, 3'b100, 8'd1});
        end
        drive(L_0, 3);
        nvec++;
        if (st !== {1'b0, 2'b00, 3'b100, 8'd1}) begin
            nerr++; $display("FAIL onehot_sticky: status=%h want=%h", st, {1'b0, 2'b00, 3'b100, 8'd1});
        end
        err_clr = 1'b1; drive(L_0, 1); err_clr = 1'b0;
        nvec++;
        if (st !== {1'b0, 2'b00, 3'b000, 8'd1}) begin
            nerr++; $display("FAIL onehot_clear: status=%h want=%h", st, {1'b0, 2'b00, 3'b000, 8'd1});
        end
        drive(L_R, 1);
        err_clr = 1'b1; drive(L_R | L_G, 1); err_clr = 1'b0;
        nvec++;
        if (st !== {1'b0, 2'b00, 3'b100, 8'd1}) begin
            nerr++; $display("FAIL error_beats_clear: status=%h want=%h", st, {1'b0, 2'b00, 3'b100, 8'd1});
        end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        drive(L_R, 2);
        for (int k = 0; k < 300; k++) begin
            drive(L_G, 8); drive(L_Y, 3); drive(L_R, 6);
        end
        nvec++;
        if (st !== {1'b1, 2'b11, 3'b000, 8'd255}) begin
            nerr++; $display("FAIL cnt_saturate: status=%h want=%h", st, {1'b1, 2'b11, 3'b000, 8'd255});
        end
        drive(L_G, 3);
        nvec++;
        if (st !== {1'b1, 2'b01, 3'b000, 8'd255}) begin
            nerr++; $display("FAIL cnt_hold_255: status=%h want=%h", st, {1'b1, 2'b01, 3'b000, 8'd255});
        end
        rst = 1'b0; drive(L_G, 2);
        nvec++;
        if (st !== {1'b0, 2'b00, 3'b000, 8'd0}) begin
            nerr++; $display("FAIL mid_green_reset: status=%h want=%h", st, {1'b0, 2'b00, 3'b000, 8'd0});
        end
        rst = 1'b1; drive(L_G, 1);
        nvec++;
        if (st !== {1'b1, 2'b01, 3'b000, 8'd0}) begin
            nerr++; $display("FAIL relock: status=%h want=%h", st, {1'b1, 2'b01, 3'b000, 8'd0});
        end
        drive(L_G, 14);
        nvec++;
        if (st !== {1'b1, 2'b01, 3'b000, 8'd0}) begin
            nerr++; $display("FAIL partial_no_timeout: status=%h want=%h", st, {1'b1, 2'b01, 3'b000, 8'd0});
        end
        drive(L_Y, 3); drive(L_R, 6); drive(L_G, 1);
        nvec++;
        if (st !== {1'b1, 2'b01, 3'b000, 8'd1}) begin
            nerr++; $display("FAIL resume_cycle: status=%h want=%h", st, {1'b1, 2'b01, 3'b000, 8'd1});
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_nominal();
        test_timing_long();
        test_timing_short();
        test_seq_onehot();
        test_saturation_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
